// File: rtl/rattlesnake_exe_trace_buffer_pkg.sv
// Shared types for the Rattlesnake execution-trace capture stage.
package rattlesnake_trace_pkg;

  localparam int unsigned TRACE_CNT_WIDTH = 16;
  localparam int unsigned TRACE_PC_WIDTH  = 32;
  localparam int unsigned TRACE_IR_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_PC_WIDTH-1:0] pc;
    logic [TRACE_IR_WIDTH-1:0] ir;
  } trace_entry_t;

  function automatic logic [TRACE_CNT_WIDTH-1:0] sat_inc(input logic [TRACE_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rattlesnake_exe_trace_buffer_if.sv
// Trace drain port: valid/ready stream of {pc, ir} entries towards the debug host.
interface rattlesnake_exe_trace_buffer_if #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned IR_WIDTH = 32
);
  logic                trace_valid;
  logic                trace_ready;
  logic [PC_WIDTH-1:0] trace_pc;
  logic [IR_WIDTH-1:0] trace_ir;

  modport master (output trace_valid, output trace_pc, output trace_ir, input trace_ready);
  modport slave  (input trace_valid, input trace_pc, input trace_ir, output trace_ready);
endinterface

// File: rtl/rattlesnake_exe_trace_buffer_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; head reads zero while empty.
module rattlesnake_trace_fifo
  import rattlesnake_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter type         entry_t    = trace_entry_t
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  entry_t            wr_data,
  output entry_t            rd_data,
  output logic              full,
  output logic              empty,
  output logic [DEPTH_LOG2:0] level
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  entry_t              mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees the slot the same-cycle push lands in, so full+pop still accepts.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/rattlesnake_exe_trace_buffer.sv
// Execution-trace capture: arm/trigger/stop FSM, session counters, and a FWFT
// FIFO of {pc, ir} pairs drained through a valid/ready port.
module rattlesnake_exe_trace_buffer
  import rattlesnake_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned IR_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sync_reset,
  input  logic                       exe_enable,
  input  logic [PC_WIDTH-1:0]        pc_in,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       flush,
  input  logic                       trigger_en,
  input  logic [PC_WIDTH-1:0]        trigger_pc,
  input  logic [TRACE_CNT_WIDTH-1:0] capture_limit,
  rattlesnake_exe_trace_buffer_if.master trace,
  output logic [DEPTH_LOG2:0]        fill_level,
  output logic [TRACE_CNT_WIDTH-1:0] captured_cnt,
  output logic [TRACE_CNT_WIDTH-1:0] overflow_cnt,
  output logic [1:0]                 state_out,
  output logic                       done
);
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [IR_WIDTH-1:0] ir;
  } entry_t;

  trace_state_t state_q, state_d;
  logic [TRACE_CNT_WIDTH-1:0] captured_q, overflow_q;
  logic [TRACE_CNT_WIDTH:0]   next_captured;
  logic   clear_cnt;
  logic   trig_hit;
  logic   sample;
  logic   pop_req;
  logic   accepted;
  logic   limit_hit;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t head;

  // Stop and arm both win over a trigger hit, so the trigger instruction is not pushed then.
  assign trig_hit  = (state_q == ARMED) && trigger_en && exe_enable &&
                     (pc_in == trigger_pc) && !stop && !arm;
  assign sample    = exe_enable && ((state_q == CAPTURE) || trig_hit);
  assign pop_req   = !fifo_empty && trace.trace_ready;
  assign accepted  = sample && !flush && (!fifo_full || pop_req);

  assign next_captured = {1'b0, captured_q} + 1'b1;
  assign limit_hit     = accepted && (capture_limit != '0) &&
                         (next_captured >= {1'b0, capture_limit});

  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d   = ARMED;
          clear_cnt = 1'b1;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = DONE;
        end else if (arm) begin
          clear_cnt = 1'b1;
        end else if (!trigger_en || trig_hit) begin
          state_d = limit_hit ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_d = DONE;
        end else if (arm) begin
          state_d   = ARMED;
          clear_cnt = 1'b1;
        end else if (limit_hit) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      captured_q <= '0;
      overflow_q <= '0;
    end else if (sync_reset) begin
      state_q    <= IDLE;
      captured_q <= '0;
      overflow_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear_cnt) begin
        captured_q <= '0;
        overflow_q <= '0;
      end else if (accepted) begin
        captured_q <= sat_inc(captured_q);
      end else if (sample && !flush) begin
        overflow_q <= sat_inc(overflow_q);
      end
    end
  end

  rattlesnake_trace_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .entry_t    (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush || sync_reset),
    .push    (sample),
    .pop     (pop_req),
    .wr_data ('{pc: pc_in, ir: ir_in}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  assign trace.trace_valid = !fifo_empty;
  assign trace.trace_pc    = head.pc;
  assign trace.trace_ir    = head.ir;
  assign captured_cnt      = captured_q;
  assign overflow_cnt      = overflow_q;
  assign state_out         = state_q;
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_rattlesnake_exe_trace_buffer.sv
// Directed bench for the execution-trace buffer with a scoreboard of expected drain entries.
module tb_rattlesnake_exe_trace_buffer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_reset = 1'b0;
  logic        exe_enable = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] ir_in = '0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        flush = 1'b0;
  logic        trigger_en = 1'b0;
  logic [31:0] trigger_pc = '0;
  logic [15:0] capture_limit = '0;
  logic [4:0]  fill_level;
  logic [15:0] captured_cnt;
  logic [15:0] overflow_cnt;
  logic [1:0]  state_out;
  logic        done;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [63:0] sb [$];

  rattlesnake_exe_trace_buffer_if #(.PC_WIDTH(32), .IR_WIDTH(32)) trace_bus ();

  rattlesnake_exe_trace_buffer #(.DEPTH_LOG2(4), .PC_WIDTH(32), .IR_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_reset    (sync_reset),
    .exe_enable    (exe_enable),
    .pc_in         (pc_in),
    .ir_in         (ir_in),
    .arm           (arm),
    .stop          (stop),
    .flush         (flush),
    .trigger_en    (trigger_en),
    .trigger_pc    (trigger_pc),
    .capture_limit (capture_limit),
    .trace         (trace_bus),
    .fill_level    (fill_level),
    .captured_cnt  (captured_cnt),
    .overflow_cnt  (overflow_cnt),
    .state_out     (state_out),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: head checked against the scoreboard before the edge, outputs sampled #1 after.
  task automatic cycle(input logic e, input logic [31:0] pc, input logic rdy, input logic exp_acc);
    logic [63:0] head;
    exe_enable = e;
    pc_in      = pc;
    ir_in      = ir_of(pc);
    trace_bus.trace_ready = rdy;
    chk("trace_valid", trace_bus.trace_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      head = sb[0];
      chk("head_pc", trace_bus.trace_pc, head[63:32]);
      chk("head_ir", trace_bus.trace_ir, head[31:0]);
      if (rdy) void'(sb.pop_front());
    end
    if (exp_acc) sb.push_back({pc, ir_of(pc)});
    @(posedge clk);
    #1;
    exe_enable = 1'b0;
    arm        = 1'b0;
    stop       = 1'b0;
    flush      = 1'b0;
    sync_reset = 1'b0;
    trace_bus.trace_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) cycle(1'b0, 32'h0, (i % 2) == 0, 1'b0);
    chk("drain_fill", fill_level, 0);
    chk("drain_valid", trace_bus.trace_valid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state_out, 0);
    chk({tag, "_valid"}, trace_bus.trace_valid, 0);
    chk({tag, "_pc"}, trace_bus.trace_pc, 0);
    chk({tag, "_ir"}, trace_bus.trace_ir, 0);
    chk({tag, "_fill"}, fill_level, 0);
    chk({tag, "_captured"}, captured_cnt, 0);
    chk({tag, "_overflow"}, overflow_cnt, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    trace_bus.trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Immediate capture with a limit of 4
    trigger_en    = 1'b0;
    capture_limit = 16'd4;
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s1_armed", state_out, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s1_capture", state_out, 2);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, i < 4);
      if (i == 0) chk("s1_latency_pc", trace_bus.trace_pc, 32'h8000_0000);
    end
    chk("s1_fill", fill_level, 4);
    chk("s1_done", done, 1);
    chk("s1_state", state_out, 3);
    chk("s1_captured", captured_cnt, 4);
    chk("s1_overflow", overflow_cnt, 0);
    drain();

    // Trigger on 0x80000010, stop after three samples
    trigger_en    = 1'b1;
    trigger_pc    = 32'h8000_0010;
    capture_limit = 16'd0;
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s2_armed", state_out, 1);
    chk("s2_cleared", captured_cnt, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) chk("s2_pre_trigger", state_out, 1);
      cycle(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, i >= 4);
      if (i == 4) begin
        chk("s2_post_trigger", state_out, 2);
        chk("s2_first_pc", trace_bus.trace_pc, 32'h8000_0010);
        chk("s2_first_ir", trace_bus.trace_ir, ir_of(32'h8000_0010));
      end
    end
    stop = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s2_captured", captured_cnt, 3);
    chk("s2_state", state_out, 3);
    drain();

    // Overflow, then push and pop together while full
    trigger_en = 1'b0;
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s3_capture", state_out, 2);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h9000_0000 + 32'(4 * i), 1'b0, i < 16);
    chk("s3_fill_full", fill_level, 16);
    chk("s3_overflow", overflow_cnt, 4);
    chk("s3_captured", captured_cnt, 16);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h9000_0050 + 32'(4 * i), 1'b1, 1'b1);
      chk("s3_fill_steady", fill_level, 16);
    end
    chk("s3_overflow_after", overflow_cnt, 4);
    chk("s3_captured_after", captured_cnt, 21);
    stop = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s3_done", state_out, 3);
    drain();

    // Flush beats a same-cycle sample and pop; arm+stop together ends in DONE
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA000_0000 + 32'(4 * i), 1'b0, 1'b1);
    chk("s4_fill", fill_level, 3);
    flush = 1'b1;
    cycle(1'b1, 32'hA000_000C, 1'b1, 1'b0);
    sb.delete();
    chk("s4_flush_fill", fill_level, 0);
    chk("s4_flush_valid", trace_bus.trace_valid, 0);
    chk("s4_flush_overflow", overflow_cnt, 0);
    chk("s4_flush_captured", captured_cnt, 3);
    chk("s4_flush_state", state_out, 2);
    arm  = 1'b1;
    stop = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s4_armstop_state", state_out, 3);
    chk("s4_armstop_captured", captured_cnt, 3);

    // Synchronous reset from ARMED
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    sync_reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk_all_zero("sync_reset");

    // Asynchronous reset mid-capture
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB000_0000, 1'b0, 1'b1);
    cycle(1'b1, 32'hB000_0004, 1'b0, 1'b1);
    chk("s5_fill", fill_level, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    arm = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC000_0000, 1'b0, 1'b1);
    chk("s5_captured", captured_cnt, 1);
    chk("s5_overflow", overflow_cnt, 0);
    chk("s5_fill_after", fill_level, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rattlesnake_exe_trace_buffer.md
Name: rattlesnake_exe_trace_buffer

Overview:
Synthesizable execution-trace capture stage that sits directly downstream of the Rattlesnake execution unit. It samples {PC_in, IR_in} on every exe_enable cycle and stores the pairs in an on-chip FIFO. Capture can be gated by an arm/trigger/stop control FSM. A valid/ready port drains the FIFO to a debug host (UART/OCD bridge), so the comparison the simulation bench does against golden vectors can also be done on silicon.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
PC_WIDTH, 32, width of sampled PC
IR_WIDTH, 32, width of sampled instruction word

Ports:
clk  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous reset, same effect as reset_n
exe_enable  in  1  execution unit consumes an instruction this cycle
pc_in  in  PC_WIDTH  PC of the instruction in execute
ir_in  in  IR_WIDTH  instruction word in execute
arm  in  1  pulse: start a capture session
stop  in  1  pulse: end the capture session
flush  in  1  pulse: empty the FIFO
trigger_en  in  1  1 = wait for trigger_pc, 0 = capture immediately
trigger_pc  in  PC_WIDTH  trigger address
capture_limit  in  16  entries per session, 0 = unlimited
trace_ready  in  1  consumer accepts the head entry
trace_valid  out  1  FIFO not empty
trace_pc  out  PC_WIDTH  head-entry PC
trace_ir  out  IR_WIDTH  head-entry IR
fill_level  out  DEPTH_LOG2+1  current FIFO occupancy
captured_cnt  out  16  entries accepted this session
overflow_cnt  out  16  samples dropped because the FIFO was full; saturates at 16'hFFFF
state_out  out  2  FSM state encoding
done  out  1  high while state is DONE

Behaviour:
- Reset (reset_n low, async; or sync_reset high at the edge): state IDLE; FIFO empty; all counters 0. All outputs 0; trace_pc and trace_ir read 0 when the FIFO is empty after reset.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE/DONE: arm -> ARMED. Arm clears captured_cnt and overflow_cnt. FIFO contents are kept.
  - ARMED: if trigger_en=0 -> CAPTURE on the next edge. If trigger_en=1 and exe_enable and pc_in==trigger_pc, the triggering instruction is pushed in the same cycle and the state goes to CAPTURE.
  - CAPTURE: each exe_enable cycle is a sample. When capture_limit!=0 and the accepted push brings captured_cnt to capture_limit -> DONE.
  - stop in ARMED or CAPTURE -> DONE. Stop beats arm and trigger in the same cycle. Arm in ARMED or CAPTURE re-arms (counters cleared, state ARMED).
- Sample = exe_enable && (state==CAPTURE || trigger hit in ARMED).
  - Push accepted if fill_level < DEPTH, or if a pop happens in the same cycle.
  - Accepted push: captured_cnt++. Rejected push: overflow_cnt++ (saturating). Neither counter wraps; captured_cnt saturates at 16'hFFFF.
- Pop = trace_valid && trace_ready.
- FIFO is first-word-fall-through. An entry written at edge N shows on trace_valid/trace_pc/trace_ir after edge N, so latency is 1 cycle.
- Pointers are DEPTH_LOG2+1 bits. Full when the MSBs differ and the low bits are equal. Pointers wrap modulo 2*DEPTH.
- Head data is stable while trace_valid && !trace_ready.
- flush (synchronous): pointers reset and fill_level becomes 0. Flush has priority over a push and a pop in the same cycle; the dropped push is not counted as overflow. Flush does not change the state or the counters.
- Simultaneous push and pop when full: both happen and fill_level is unchanged. When empty there is no pop, so no bypass and no same-cycle fall-through.
- Reset mid-session returns to IDLE with the FIFO empty.

Decomposition:
- Package rattlesnake_trace_pkg holds:
  - the trace_state_t enum (IDLE/ARMED/CAPTURE/DONE, 2-bit);
  - TRACE_CNT_WIDTH=16;
  - the trace_entry_t struct {pc, ir}.
- Sub-module rattlesnake_trace_fifo:
  - parameterized FWFT FIFO with push, pop, flush, full, empty, level;
  - the top level holds the FSM and counters.

Test Plan:
- trigger_en=0, capture_limit=4, arm, 6 consecutive exe_enable cycles with PC 0x80000000..+4, trace_ready=0 -> the first 4 entries are stored, fill_level=4, done=1, captured_cnt=4, overflow_cnt=0.
- trigger_en=1, trigger_pc=0x80000010, PCs stepping from 0x80000000 -> the first entry is 0x80000010 with its IR and state goes ARMED->CAPTURE on the same edge. Stop after 3 samples -> captured_cnt=3, DONE.
- DEPTH=16, capture_limit=0, 20 samples with trace_ready=0 -> fill_level=16, overflow_cnt=4. Then with trace_ready=1 and continuous samples: push and pop together at full, fill_level stays 16.
- Drain with trace_ready toggling 1/0 -> entries come out in order, and data is held while ready=0.
- flush asserted in the same cycle as a sample and a pop -> fill_level=0, overflow_cnt unchanged. Arm and stop asserted together in CAPTURE -> DONE.
- reset_n pulsed low mid-CAPTURE (asynchronously, between edges) -> all outputs are 0 and state IDLE immediately. After reset, arm -> counters start from 0.
